// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle: decode stall, execute redirect, instruction-memory port and F/D register outputs.
// The slave modport is the fetch unit; the master modport is the surrounding pipeline/memory.
interface fetch_pc_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        fd_valid;
  logic [11:0] fd_pc;
  logic [31:0] fd_insn;
  logic        fd_pred_taken;
  logic [11:0] fd_pred_pc;
  logic        flush_dx;

  modport master (
    output stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, fd_valid, fd_pc, fd_insn, fd_pred_taken, fd_pred_pc, flush_dx
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, fd_valid, fd_pc, fd_insn, fd_pred_taken, fd_pred_pc, flush_dx
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, imem address, F/D capture and redirect handling.
// Define FETCH_PREDICT_EN to build j/jal/jr prediction with a circular return-address stack.
module fetch_pc_unit #(
  parameter int RAS_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  fetch_pc_unit_if.slave fetch
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_pc_unit: RAS_DEPTH must be a power of two in 2..16");
  end

  logic [11:0] pc_p0;
  logic        fd_valid_p1;
  logic [11:0] fd_pc_p1;
  logic [31:0] fd_insn_p1;
  logic        fd_pred_taken_p1;
  logic [11:0] fd_pred_pc_p1;
  logic        flush_dx_p1;

  logic [11:0] seq_pc;
  logic        advance;
  logic        pred_taken;
  logic [11:0] pred_pc;

  assign seq_pc  = pc_p0 + 12'd1;
  assign advance = !fetch.redirect_valid && !fetch.stall;

`ifdef FETCH_PREDICT_EN
  localparam int                 PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]     RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [4:0]         OP_J     = 5'b00001;
  localparam logic [4:0]         OP_JAL   = 5'b00011;
  localparam logic [4:0]         OP_JR    = 5'b00100;

  logic [11:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W:0]   ras_cnt;
  logic [4:0]       opcode;
  logic             ras_push;
  logic             ras_pop;

  assign opcode = fetch.imem_data[31:27];

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = seq_pc;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    case (opcode)
      OP_J: begin
        pred_taken = 1'b1;
        pred_pc    = fetch.imem_data[11:0];
      end
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = fetch.imem_data[11:0];
        ras_push   = advance;
      end
      OP_JR: begin
        // Empty stack falls back to sequential, not-taken.
        if (ras_cnt != '0) begin
          pred_taken = 1'b1;
          pred_pc    = ras_mem[ras_ptr - PTR_ONE];
          ras_pop    = advance;
        end
      end
      default: ;
    endcase
  end

  // RAS control: ptr is the next write slot; occupancy saturates when full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_ONE;
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + CNT_ONE;
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - PTR_ONE;
      ras_cnt <= ras_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (ras_push) ras_mem[ras_ptr] <= seq_pc;
  end
`else
  assign pred_taken = 1'b0;
  assign pred_pc    = seq_pc;
`endif

  // Stage p0 -> p1: PC register and F/D capture; redirect beats stall beats advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_p0            <= 12'h000;
      fd_valid_p1      <= 1'b0;
      fd_pc_p1         <= 12'h000;
      fd_insn_p1       <= 32'h0;
      fd_pred_taken_p1 <= 1'b0;
      fd_pred_pc_p1    <= 12'h000;
      flush_dx_p1      <= 1'b0;
    end else if (fetch.redirect_valid) begin
      pc_p0       <= fetch.redirect_pc;
      fd_valid_p1 <= 1'b0;
      flush_dx_p1 <= 1'b1;
    end else if (fetch.stall) begin
      flush_dx_p1 <= 1'b0;
    end else begin
      pc_p0            <= pred_pc;
      fd_valid_p1      <= 1'b1;
      fd_pc_p1         <= pc_p0;
      fd_insn_p1       <= fetch.imem_data;
      fd_pred_taken_p1 <= pred_taken;
      fd_pred_pc_p1    <= pred_pc;
      flush_dx_p1      <= 1'b0;
    end
  end

  assign fetch.imem_addr     = pc_p0;
  assign fetch.fd_valid      = fd_valid_p1;
  assign fetch.fd_pc         = fd_pc_p1;
  assign fetch.fd_insn       = fd_insn_p1;
  assign fetch.fd_pred_taken = fd_pred_taken_p1;
  assign fetch.fd_pred_pc    = fd_pred_pc_p1;
  assign fetch.flush_dx      = flush_dx_p1;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a queue-based fetch model checked every cycle plus literal expectations.
module tb_fetch_pc_unit;
  localparam int RAS_DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   run_chk = 1'b1;

  logic [31:0] mem [4096];

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RAS_DEPTH(RAS_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .fetch (bus.slave)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  always #5 clock = ~clock;

  // Reference state
  logic [11:0] m_pc;
  bit          m_fd_valid;
  logic [11:0] m_fd_pc;
  logic [31:0] m_fd_insn;
  bit          m_pt;
  logic [11:0] m_ppc;
  bit          m_flush;
  logic [11:0] ras_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_fd_valid = 0; m_fd_pc = 12'h000; m_fd_insn = 32'h0;
    m_pt = 0; m_ppc = 12'h000; m_flush = 0;
    ras_q.delete();
  endtask

  task automatic predict(input logic [11:0] pc, input logic [31:0] w,
                         output bit tk, output logic [11:0] np);
    tk = 0;
    np = pc + 12'd1;
`ifdef FETCH_PREDICT_EN
    case (w[31:27])
      5'b00001: begin tk = 1; np = w[11:0]; end
      5'b00011: begin
        tk = 1; np = w[11:0];
        ras_q.push_back(pc + 12'd1);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
      end
      5'b00100: if (ras_q.size() > 0) begin tk = 1; np = ras_q.pop_back(); end
      default: ;
    endcase
`else
    if (w === 32'hx) tk = 0;
`endif
  endtask

  task automatic model_step(input bit st, input bit rv, input logic [11:0] rpc);
    bit          tk;
    logic [11:0] np;
    if (rv) begin
      m_pc = rpc; m_fd_valid = 0; m_flush = 1;
    end else if (st) begin
      m_flush = 0;
    end else begin
      predict(m_pc, mem[m_pc], tk, np);
      m_fd_valid = 1; m_fd_pc = m_pc; m_fd_insn = mem[m_pc];
      m_pt = tk; m_ppc = np; m_pc = np; m_flush = 0;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, return at the next falling edge.
  task automatic cyc(input bit st, input bit rv, input logic [11:0] rpc);
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    @(posedge clock);
    model_step(st, rv, rpc);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (run_chk) begin
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("fd_valid", 32'(bus.fd_valid), 32'(m_fd_valid));
      chk("flush_dx", 32'(bus.flush_dx), 32'(m_flush));
      if (m_fd_valid) begin
        chk("fd_pc", 32'(bus.fd_pc), 32'(m_fd_pc));
        chk("fd_insn", bus.fd_insn, m_fd_insn);
        chk("fd_pred_taken", 32'(bus.fd_pred_taken), 32'(m_pt));
        chk("fd_pred_pc", 32'(bus.fd_pred_pc), 32'(m_ppc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {5'b10110, 15'(i * 7), 12'(i ^ 12'h5A5)};
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 12'h000;
    model_reset();

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h000);
    chk("rst_fd_valid", 32'(bus.fd_valid), 32'h0);
    chk("rst_fd_pc", 32'(bus.fd_pc), 32'h000);
    chk("rst_fd_insn", bus.fd_insn, 32'h0);
    chk("rst_pred_taken", 32'(bus.fd_pred_taken), 32'h0);
    chk("rst_pred_pc", 32'(bus.fd_pred_pc), 32'h000);
    chk("rst_flush", 32'(bus.flush_dx), 32'h0);
    reset = 1'b1;

    // Sequential fetch from 0
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 12'h000);
      chk("seq_fd_pc", 32'(bus.fd_pc), 32'(i));
      chk("seq_fd_valid", 32'(bus.fd_valid), 32'h1);
      chk("seq_fd_insn", bus.fd_insn, {5'b10110, 15'(i * 7), 12'(i ^ 12'h5A5)});
      chk("seq_pred_pc", 32'(bus.fd_pred_pc), 32'(i + 1));
      chk("seq_flush", 32'(bus.flush_dx), 32'h0);
    end
    cyc(0, 0, 12'h000);

    // Stall at PC 5
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 12'h000);
      chk("stall_imem_addr", 32'(bus.imem_addr), 32'h005);
      chk("stall_fd_pc", 32'(bus.fd_pc), 32'h004);
    end
    cyc(0, 0, 12'h000);
    chk("post_stall_fd_pc", 32'(bus.fd_pc), 32'h005);

    // Redirect wins over stall
    cyc(1, 1, 12'h0A0);
    chk("redir_imem_addr", 32'(bus.imem_addr), 32'h0A0);
    chk("redir_fd_valid", 32'(bus.fd_valid), 32'h0);
    chk("redir_flush", 32'(bus.flush_dx), 32'h1);
    cyc(0, 0, 12'h000);
    chk("redir2_flush", 32'(bus.flush_dx), 32'h0);
    chk("redir2_fd_pc", 32'(bus.fd_pc), 32'h0A0);

    // Back-to-back redirects, then PC wrap
    cyc(0, 1, 12'hFFE);
    chk("b2b_flush0", 32'(bus.flush_dx), 32'h1);
    cyc(0, 1, 12'hFFF);
    chk("b2b_flush1", 32'(bus.flush_dx), 32'h1);
    cyc(0, 0, 12'h000);
    chk("wrap_imem_addr", 32'(bus.imem_addr), 32'h000);
    chk("wrap_fd_pc", 32'(bus.fd_pc), 32'hFFF);
    chk("wrap_pred_pc", 32'(bus.fd_pred_pc), 32'h000);

    // Mixed stall/redirect pattern
    for (int i = 0; i < 24; i++)
      cyc(i % 5 == 2, i % 7 == 3, 12'(12'h100 + i * 3));

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_imem_addr", 32'(bus.imem_addr), 32'h000);
    chk("async_fd_valid", 32'(bus.fd_valid), 32'h0);
    chk("async_fd_pc", 32'(bus.fd_pc), 32'h000);
    @(negedge clock);
    reset = 1'b1;
    cyc(0, 0, 12'h000);
    chk("after_async_fd_pc", 32'(bus.fd_pc), 32'h000);

`ifdef FETCH_PREDICT_EN
    mem[12'h010] = {5'b00011, 15'h0, 12'h200};
    mem[12'h200] = {5'b00100, 15'h0, 12'h000};
    mem[12'h011] = {5'b00100, 15'h0, 12'h000};
    cyc(0, 1, 12'h010);
    cyc(0, 0, 12'h000);
    chk("jal_pred_pc", 32'(bus.fd_pred_pc), 32'h200);
    chk("jal_pred_taken", 32'(bus.fd_pred_taken), 32'h1);
    cyc(0, 0, 12'h000);
    chk("jr_pred_pc", 32'(bus.fd_pred_pc), 32'h011);
    cyc(0, 0, 12'h000);
    chk("jr_empty_taken", 32'(bus.fd_pred_taken), 32'h0);
    chk("jr_empty_pc", 32'(bus.fd_pred_pc), 32'h012);

    for (int i = 0; i < 5; i++) mem[12'h300 + i] = {5'b00011, 15'h0, 12'(12'h301 + i)};
    mem[12'h400] = {5'b00100, 15'h0, 12'h000};
    cyc(0, 1, 12'h300);
    for (int i = 0; i < 5; i++) cyc(0, 0, 12'h000);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 12'h400);
      cyc(0, 0, 12'h000);
      if (k < 4) begin
        chk("ras_pop_pc", 32'(bus.fd_pred_pc), 32'(12'h305 - k));
        chk("ras_pop_taken", 32'(bus.fd_pred_taken), 32'h1);
      end else begin
        chk("ras_empty_pc", 32'(bus.fd_pred_pc), 32'h401);
        chk("ras_empty_taken", 32'(bus.fd_pred_taken), 32'h0);
      end
    end
`endif

    run_chk = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the five-stage core: owns the architectural PC register, drives the instruction-memory address, and captures the fetched instruction into the F/D pipeline register. It is the consuming end of the next-PC path. Execute resolves branches and jumps and sends a redirect PC here. This block holds the PC on stalls, flushes F/D on redirects, and otherwise advances sequentially or by its own jump prediction.

## Interface
Parameters:
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2–16; used only with prediction compiled in.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall from decode; holds PC and F/D.
- redirect_valid  in  1  execute resolved a taken branch/jump or a misprediction.
- redirect_pc  in  12  corrected next PC, valid with redirect_valid.
- imem_addr  out  12  current PC, combinationally equal to the PC register.
- imem_data  in  32  instruction at imem_addr, asynchronous read, valid in the same cycle.
- fd_valid  out  1  F/D holds a live instruction.
- fd_pc  out  12  PC of the F/D instruction.
- fd_insn  out  32  F/D instruction word.
- fd_pred_taken  out  1  fetch predicted a non-sequential next PC.
- fd_pred_pc  out  12  next PC fetch chose after this instruction; execute compares it against the resolved PC.
- flush_dx  out  1  registered one-cycle pulse, asserted the cycle after a redirect edge; clears D/X.

## Operation
- Reset (reset low, asynchronous):
  - PC=12'h000; fd_valid=0, fd_pc=0, fd_insn=0, fd_pred_taken=0, fd_pred_pc=0.
  - flush_dx=0; RAS empty with pointer 0.
- Priority at each rising edge: redirect_valid > stall > normal advance.
- Redirect:
  - PC<=redirect_pc; fd_valid<=0 (fd_pc/fd_insn don't-care); flush_dx<=1.
  - Applies even when stall is asserted in the same cycle.
  - RAS is not repaired.
- Stall without redirect: PC and every fd_* output hold; no RAS push or pop; flush_dx<=0.
- Normal advance:
  - fd_valid<=1, fd_pc<=PC, fd_insn<=imem_data.
  - fd_pred_taken and fd_pred_pc take the prediction made this cycle.
  - PC<=fd_pred_pc value; flush_dx<=0.
- Sequential next PC is PC+1 mod 4096; 12'hFFF wraps to 12'h000 with no flag.
- Opcode is imem_data[31:27]: j=5'b00001, jal=5'b00011, jr=5'b00100. Jump target is imem_data[11:0].

## Timing
- Fetch latency: an address presented in cycle n has its instruction visible on fd_* from cycle n+1.
- After reset deasserts, the first edge captures address 0. fd_valid rises after that edge.
- Redirect penalty: the instruction fetched in the redirect cycle is discarded. The redirect target is presented on imem_addr in the cycle after the edge, and reaches F/D one edge later.
- Redirect and stall in the same cycle: redirect wins.
- flush_dx is high for exactly one cycle per redirect edge. Back-to-back redirects keep it high continuously.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.

## Configuration
- FETCH_PREDICT_EN undefined:
  - Next PC is always PC+1; fd_pred_taken=0; fd_pred_pc=PC+1.
  - No RAS is synthesized. Every jump costs one redirect.
- FETCH_PREDICT_EN defined:
  - j: predict taken to target.
  - jal: predict taken to target, and push PC+1 onto the RAS.
  - jr: pop the RAS top and predict taken to it. An empty RAS predicts PC+1, not taken.
  - Conditional branches are predicted not taken.
  - RAS is circular: a push when full overwrites the oldest entry and occupancy saturates at RAS_DEPTH.
  - Wrong-path pushes and pops are not undone; execute corrects them via redirect.
  - Push and pop happen only on a normal-advance edge.

## Test plan
- Reset, then run 4 cycles with no stall or redirect over instructions at 0..3 -> fd_pc = 0,1,2,3 on successive cycles, fd_valid=1 from the first edge, flush_dx=0.
- Stall asserted for 3 cycles at PC=5 -> imem_addr stays 5 and fd_* hold for 3 cycles; the next edge captures PC 5.
- redirect_valid=1 with redirect_pc=12'h0A0 and stall=1 at the same edge -> next cycle imem_addr=12'h0A0, fd_valid=0, flush_dx=1; one cycle later flush_dx=0 and fd_pc=12'h0A0.
- PC=12'hFFF, no stall -> next imem_addr=12'h000 and fd_pc=12'hFFF.
- FETCH_PREDICT_EN: jal at PC 12'h010 targeting 12'h200, then jr at 12'h200 -> fd_pred_pc=12'h200, then 12'h011; a jr with an empty RAS gives fd_pred_taken=0.
- FETCH_PREDICT_EN, RAS_DEPTH=4: five jal pushes with return addresses A1..A5, then five jr pops -> predictions A5, A4, A3, A2, then PC+1 with fd_pred_taken=0.
